// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg
//   Shared constants and helpers for the async_fifo block.
//   DATA_WIDTH  - default word width
//   ADDR_WIDTH  - log2 of the FIFO depth
//   DEPTH       - number of storage entries
//   SYNC_STAGES - flops per pointer synchronizer
//   PTR_WIDTH   - pointer width (address plus wrap bit)
//   bin2gray()  - binary to reflected-gray conversion of a pointer
package async_fifo_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int ADDR_WIDTH  = 4;
  localparam int DEPTH       = 1 << ADDR_WIDTH;
  localparam int SYNC_STAGES = 2;
  localparam int PTR_WIDTH   = ADDR_WIDTH + 1;

  // Adjacent gray codes differ in one bit, so a synchronizer that samples
  // the pointer mid-change sees either the old or the new value.
  function automatic logic [PTR_WIDTH-1:0] bin2gray(input logic [PTR_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/async_fifo_ptr_sync.sv
// async_fifo_ptr_sync
//   Multi-flop synchronizer carrying a gray-coded pointer to the other side.
//   clk_in  - destination-side clock
//   rst     - synchronous active-high reset, clears every stage
//   ptr_src - gray pointer from the source side
//   ptr_dst - synchronized copy, STAGES cycles later
module async_fifo_ptr_sync #(
  parameter int WIDTH  = async_fifo_pkg::PTR_WIDTH,
  parameter int STAGES = async_fifo_pkg::SYNC_STAGES
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [WIDTH-1:0] ptr_src,
  output logic [WIDTH-1:0] ptr_dst
);

  import async_fifo_pkg::*;

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk_in) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= '0;
      end
    end else begin
      chain[0] <= ptr_src;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign ptr_dst = chain[STAGES-1];

endmodule

// File: rtl/async_fifo.sv
// async_fifo
//   16 x 32 FIFO with gray-coded pointers crossed through synchronizers.
//   Both sides run on clk_in today; the pointer-crossing structure is kept so
//   the write and read sides can be moved onto separate clocks later.
//   clk_in   - clock, all state updates on the rising edge
//   rst      - synchronous active-high reset
//   i_wdata  - write data
//   i_wr     - write request, accepted when not full
//   i_rd     - read request, accepted when not empty
//   o_wfull  - registered full flag (conservative)
//   o_rempty - registered empty flag (conservative)
//   o_rdata  - registered read data, valid the cycle after an accepted read
module async_fifo #(
  parameter int DATA_WIDTH  = async_fifo_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH  = async_fifo_pkg::ADDR_WIDTH,
  parameter int SYNC_STAGES = async_fifo_pkg::SYNC_STAGES
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_wr,
  input  logic                  i_rd,
  output logic                  o_wfull,
  output logic                  o_rempty,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  import async_fifo_pkg::*;

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int MEM_DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [PTR_W-1:0] wbin, wbin_next, wgray, wgray_next;
  logic [PTR_W-1:0] rbin, rbin_next, rgray, rgray_next;
  logic [PTR_W-1:0] rq_wgray, wq_rgray;
  logic             wr_accept, rd_accept;
  logic             wfull_next, rempty_next;

  always_comb begin
    wr_accept  = i_wr && !o_wfull;
    rd_accept  = i_rd && !o_rempty;
    wbin_next  = wbin + {{(PTR_W-1){1'b0}}, wr_accept};
    rbin_next  = rbin + {{(PTR_W-1){1'b0}}, rd_accept};
    wgray_next = bin2gray(wbin_next);
    rgray_next = bin2gray(rbin_next);
    // Full when the write pointer is a whole lap ahead of the read pointer.
    // In gray code that means the top two bits are inverted and the rest match.
    wfull_next  = (wgray_next == {~wq_rgray[PTR_W-1:PTR_W-2], wq_rgray[PTR_W-3:0]});
    rempty_next = (rgray_next == rq_wgray);
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_in) begin
    if (!rst && wr_accept) begin
      mem[wbin[ADDR_WIDTH-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      wbin    <= '0;
      wgray   <= '0;
      o_wfull <= 1'b0;
    end else begin
      wbin    <= wbin_next;
      wgray   <= wgray_next;
      o_wfull <= wfull_next;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      rbin     <= '0;
      rgray    <= '0;
      o_rempty <= 1'b1;
      o_rdata  <= '0;
    end else begin
      rbin     <= rbin_next;
      rgray    <= rgray_next;
      o_rempty <= rempty_next;
      if (rd_accept) begin
        o_rdata <= mem[rbin[ADDR_WIDTH-1:0]];
      end
    end
  end

  async_fifo_ptr_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_sync_wgray (
    .clk_in  (clk_in),
    .rst     (rst),
    .ptr_src (wgray),
    .ptr_dst (rq_wgray)
  );

  async_fifo_ptr_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_sync_rgray (
    .clk_in  (clk_in),
    .rst     (rst),
    .ptr_src (rgray),
    .ptr_dst (wq_rgray)
  );

endmodule

// File: tb/tb_async_fifo.sv
// tb_async_fifo
//   Directed bench for async_fifo: reset, overfill/drain, full- and
//   empty-side flag latency, mid-operation reset and a wrap-around stream.
module tb_async_fifo;

  logic        clk_in = 1'b0;
  logic        rst;
  logic [31:0] i_wdata;
  logic        i_wr;
  logic        i_rd;
  logic        o_wfull;
  logic        o_rempty;
  logic [31:0] o_rdata;

  int assertion_count = 0;
  int failure_count   = 0;

  async_fifo dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .i_wdata  (i_wdata),
    .i_wr     (i_wr),
    .i_rd     (i_rd),
    .o_wfull  (o_wfull),
    .o_rempty (o_rempty),
    .o_rdata  (o_rdata)
  );

  always #5 clk_in = ~clk_in;

  // Drive one cycle of inputs, then let outputs settle just past the edge.
  task automatic applyStimulus(input logic rst_v, input logic wr, input logic rd,
                               input logic [31:0] data);
    rst     = rst_v;
    i_wr    = wr;
    i_rd    = rd;
    i_wdata = data;
    @(posedge clk_in);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertion_count++;
    assert (observed === expected) else begin
      failure_count++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkFlags(input string tag, input logic exp_empty, input logic exp_full);
    checkOutput({tag, "_rempty"}, {31'd0, o_rempty}, {31'd0, exp_empty});
    checkOutput({tag, "_wfull"}, {31'd0, o_wfull}, {31'd0, exp_full});
  endtask

  initial begin
    rst     = 1'b1;
    i_wr    = 1'b0;
    i_rd    = 1'b0;
    i_wdata = '0;

    // Reset and idle with ignored read pulses
    $display("[TB] reset and idle");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    checkFlags("reset", 1'b1, 1'b0);
    checkOutput("reset_rdata", o_rdata, 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
      checkFlags($sformatf("idle%0d", i), 1'b1, 1'b0);
      checkOutput($sformatf("idle%0d_rdata", i), o_rdata, 32'd0);
    end

    // Overfill with 0..19, then drain
    $display("[TB] overfill and drain");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, i);
      checkFlags($sformatf("fill%0d", i), i < 3, i >= 15);
    end
    for (int j = 0; j < 23; j++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
      checkOutput($sformatf("drain%0d_rdata", j), o_rdata, (j < 16) ? j : 15);
      checkFlags($sformatf("drain%0d", j), j >= 15, j < 3);
    end

    // Full flag lags the reader: writes during the lag are dropped
    $display("[TB] full-side latency");
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 4 + 2 * k);
      checkFlags($sformatf("even%0d", k), k < 3, k == 15);
    end
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 97 + c);
      checkOutput($sformatf("fulllag%0d_rdata", c), o_rdata, 4 + 2 * c);
      checkFlags($sformatf("fulllag%0d", c), 1'b0, 1'b1);
    end
    for (int m = 0; m < 13; m++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
      checkOutput($sformatf("evendrain%0d_rdata", m), o_rdata, 10 + 2 * m);
      checkFlags($sformatf("evendrain%0d", m), m == 12, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
    checkOutput("evenhold_rdata", o_rdata, 32'd34);
    checkFlags("evenhold", 1'b1, 1'b0);

    // Move both pointers to 9
    for (int n = 0; n < 9; n++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 200 + n);
    end
    for (int p = 0; p < 9; p++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
      checkOutput($sformatf("mid%0d_rdata", p), o_rdata, 200 + p);
      checkFlags($sformatf("mid%0d", p), p == 8, 1'b0);
    end

    // Empty flag lags the writer: reads during the lag are ignored
    $display("[TB] empty-side latency");
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 88 + c);
      checkOutput($sformatf("emptylag%0d_rdata", c), o_rdata, 32'd208);
      checkFlags($sformatf("emptylag%0d", c), 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkFlags("emptylag_fall", 1'b0, 1'b0);
    for (int q = 0; q < 3; q++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
      checkOutput($sformatf("emptyread%0d_rdata", q), o_rdata, 88 + q);
      checkFlags($sformatf("emptyread%0d", q), q == 2, 1'b0);
    end

    // Reset with 5 words stored
    $display("[TB] reset mid-operation");
    for (int n = 0; n < 5; n++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 50 + n);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    checkFlags("midrst", 1'b1, 1'b0);
    checkOutput("midrst_rdata", o_rdata, 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
      checkOutput($sformatf("postrst%0d_rdata", i), o_rdata, 32'd0);
      checkFlags($sformatf("postrst%0d", i), 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd77);
    checkFlags("rstwr0", 1'b1, 1'b0);
    checkOutput("rstwr0_rdata", o_rdata, 32'd0);
    for (int i = 1; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
      checkFlags($sformatf("rstwr%0d", i), 1'b1, 1'b0);
      checkOutput($sformatf("rstwr%0d_rdata", i), o_rdata, 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
    checkFlags("rstwr3", 1'b0, 1'b0);
    checkOutput("rstwr3_rdata", o_rdata, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
    checkOutput("rstwr4_rdata", o_rdata, 32'd77);
    checkFlags("rstwr4", 1'b1, 1'b0);

    // Streaming across the pointer wrap
    $display("[TB] wrap stress");
    for (int w = 0; w < 4; w++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, w);
    end
    for (int s = 0; s < 100; s++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 4 + s);
      checkOutput($sformatf("stream%0d_rdata", s), o_rdata, s);
      checkFlags($sformatf("stream%0d", s), 1'b0, 1'b0);
      checkOutput($sformatf("stream%0d_both", s), {31'd0, o_rempty & o_wfull}, 32'd0);
    end
    for (int u = 0; u < 4; u++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
      checkOutput($sformatf("tail%0d_rdata", u), o_rdata, 100 + u);
      checkFlags($sformatf("tail%0d", u), u == 3, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertion_count, failure_count);
    $finish;
  end

endmodule
